// File: rtl/minirv_pkg.sv
// Shared types and encodings for the miniRV multi-cycle control path.
// The imm_sel / wb_sel codes are also used by the datapath muxes.
package minirv_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_ADDI,
        OP_LUI,
        OP_LW,
        OP_LBU,
        OP_SW,
        OP_SB,
        OP_JALR,
        OP_ILLEGAL
    } op_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [6:0] F7_ADD = 7'b0000000;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_U = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    function automatic logic is_load(input op_t op);
        return (op == OP_LW) || (op == OP_LBU);
    endfunction

    function automatic logic is_store(input op_t op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational classifier: instruction word to miniRV op code.
// Anything outside the supported subset maps to OP_ILLEGAL.
module instr_decoder
    import minirv_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  op_o
);

    op_t        op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_instr_bits;

    assign f3 = instr_i[14:12];
    assign f7 = instr_i[31:25];
    // rd and rs fields never influence classification.
    assign unused_instr_bits = ^instr_i[24:7];

    always_comb begin
        op = OP_ILLEGAL;
        case (instr_i[6:0])
            OPC_OP:    if (f3 == F3_ADD && f7 == F7_ADD) op = OP_ADD;
            OPC_OPIMM: if (f3 == F3_ADD) op = OP_ADDI;
            OPC_LUI:   op = OP_LUI;
            OPC_LOAD: begin
                if (f3 == F3_W)       op = OP_LW;
                else if (f3 == F3_BU) op = OP_LBU;
            end
            OPC_STORE: begin
                if (f3 == F3_W)      op = OP_SW;
                else if (f3 == F3_B) op = OP_SB;
            end
            OPC_JALR:  if (f3 == F3_ADD) op = OP_JALR;
            default:   op = OP_ILLEGAL;
        endcase
    end

    assign op_o = op;

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the miniRV core.
// Handshake: a request stays high until its grant; the grant cycle is the transfer.
module multicycle_controller
    import minirv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STALL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        imem_gnt,
    input  logic        dmem_gnt,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [1:0]  dmem_size,
    output logic        load_unsigned,
    output logic        ir_we,
    output logic [1:0]  imm_sel,
    output logic        alu_src_imm,
    output logic        alu_a_zero,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [31:0] pc_init,
    output logic        illegal_instr,
    output logic        timeout_err,
    output logic [2:0]  state_dbg
);

    localparam int WCW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [WCW-1:0] LIMIT = WCW'(STALL_LIMIT);

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic           illegal_q, illegal_d;
    logic           timeout_q, timeout_d;
    logic           run_q;
    logic [3:0]     dec_op;

    instr_decoder u_decoder (
        .instr_i (instr),
        .op_o    (dec_op)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        wait_d        = wait_q;
        illegal_d     = illegal_q;
        timeout_d     = timeout_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_size     = SIZE_BYTE;
        load_unsigned = 1'b0;
        ir_we         = 1'b0;
        imm_sel       = IMM_I;
        alu_src_imm   = 1'b0;
        alu_a_zero    = 1'b0;
        reg_we        = 1'b0;
        wb_sel        = WB_ALU;
        pc_we         = 1'b0;
        pc_sel        = 1'b0;

        case (state_q)
            S_FETCH: begin
                // run_q holds the first fetch off until one edge after reset release.
                if (run_q) begin
                    imem_req = 1'b1;
                    if (imem_gnt) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                op_d = op_t'(dec_op);
                if (op_t'(dec_op) == OP_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = (is_load(op_q) || is_store(op_q)) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req      = 1'b1;
                dmem_we       = is_store(op_q);
                dmem_size     = (op_q == OP_LW || op_q == OP_SW) ? SIZE_WORD : SIZE_BYTE;
                load_unsigned = (op_q == OP_LBU);
                if (dmem_gnt) begin
                    if (is_store(op_q)) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we  = (instr[11:7] != 5'd0);
                pc_we   = 1'b1;
                pc_sel  = (op_q == OP_JALR);
                state_d = S_FETCH;
                if (is_load(op_q))        wb_sel = WB_LOAD;
                else if (op_q == OP_JALR) wb_sel = WB_PC4;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        // Immediate and ALU selects stay stable from EXEC through the end of the instruction.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (op_q)
                OP_ADDI, OP_LW, OP_LBU, OP_JALR: begin
                    imm_sel     = IMM_I;
                    alu_src_imm = 1'b1;
                end
                OP_SW, OP_SB: begin
                    imm_sel     = IMM_S;
                    alu_src_imm = 1'b1;
                end
                OP_LUI: begin
                    imm_sel     = IMM_U;
                    alu_src_imm = 1'b1;
                    alu_a_zero  = 1'b1;
                end
                default: ;
            endcase
        end

        if ((imem_req && !imem_gnt) || (dmem_req && !dmem_gnt)) begin
            wait_d = wait_q + WCW'(1);
            if (STALL_LIMIT != 0 && wait_d == LIMIT) begin
                timeout_d = 1'b1;
                state_d   = S_TRAP;
            end
        end else begin
            wait_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= OP_ILLEGAL;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            run_q     <= 1'b1;
        end
    end

    assign pc_init       = RESET_PC;
    assign illegal_instr = illegal_q;
    assign timeout_err   = timeout_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: driver pushes expected per-instruction
// records, an independent monitor rebuilds what it saw and compares at retire/trap.
module tb_multicycle_controller;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        imem_gnt, dmem_gnt;
    logic        imem_req, dmem_req, dmem_we, load_unsigned, ir_we;
    logic [1:0]  dmem_size, imm_sel, wb_sel;
    logic        alu_src_imm, alu_a_zero, reg_we, pc_we, pc_sel;
    logic [31:0] pc_init;
    logic        illegal_instr, timeout_err;
    logic [2:0]  state_dbg;

    logic        to_rst_n = 1'b0;
    logic        to_imem_req, to_dmem_req, to_dmem_we, to_load_unsigned, to_ir_we;
    logic [1:0]  to_dmem_size, to_imm_sel, to_wb_sel;
    logic        to_alu_src_imm, to_alu_a_zero, to_reg_we, to_pc_we, to_pc_sel;
    logic [31:0] to_pc_init;
    logic        to_illegal_instr, to_timeout_err;
    logic [2:0]  to_state_dbg;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        noise = 1'b0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    multicycle_controller u_dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .imem_gnt(imem_gnt), .dmem_gnt(dmem_gnt),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size),
        .load_unsigned(load_unsigned), .ir_we(ir_we), .imm_sel(imm_sel),
        .alu_src_imm(alu_src_imm), .alu_a_zero(alu_a_zero), .reg_we(reg_we), .wb_sel(wb_sel),
        .pc_we(pc_we), .pc_sel(pc_sel), .pc_init(pc_init), .illegal_instr(illegal_instr),
        .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    multicycle_controller #(.STALL_LIMIT(4)) u_to (
        .clk(clk), .rst_n(to_rst_n), .instr(instr), .imem_gnt(1'b0), .dmem_gnt(1'b0),
        .imem_req(to_imem_req), .dmem_req(to_dmem_req), .dmem_we(to_dmem_we),
        .dmem_size(to_dmem_size), .load_unsigned(to_load_unsigned), .ir_we(to_ir_we),
        .imm_sel(to_imm_sel), .alu_src_imm(to_alu_src_imm), .alu_a_zero(to_alu_a_zero),
        .reg_we(to_reg_we), .wb_sel(to_wb_sel), .pc_we(to_pc_we), .pc_sel(to_pc_sel),
        .pc_init(to_pc_init), .illegal_instr(to_illegal_instr), .timeout_err(to_timeout_err),
        .state_dbg(to_state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Record: {ill, latency[7:0], lu, dsize[1:0], dwe, dcnt[3:0], azero, src, imm[1:0], pcsel, wb[1:0], reg_we}
    function automatic logic [W-1:0] mk_rec(input logic rw, input logic [1:0] wb, input logic ps,
                                            input logic [1:0] im, input logic src, input logic az,
                                            input logic [3:0] dc, input logic dwe,
                                            input logic [1:0] dsz, input logic lu,
                                            input logic [7:0] lat, input logic ill);
        return {7'b0, ill, lat, lu, dsz, dwe, dc, az, src, im, ps, wb, rw};
    endfunction

    // Expected behaviour straight from the instruction table; md = data grant delay.
    function automatic logic [W-1:0] model(input logic [31:0] ins, input int md);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       rdnz;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        rdnz = (ins[11:7] != 5'd0);
        case (opc)
            7'h33: if (f3 == 3'd0 && f7 == 7'd0)
                       return mk_rec(rdnz, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 8'd4, 1'b0);
            7'h13: if (f3 == 3'd0)
                       return mk_rec(rdnz, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 8'd4, 1'b0);
            7'h37:     return mk_rec(rdnz, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0, 8'd4, 1'b0);
            7'h03: if (f3 == 3'd2 || f3 == 3'd4)
                       return mk_rec(rdnz, 2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 4'(md + 1), 1'b0,
                                     (f3 == 3'd2) ? 2'b10 : 2'b00, (f3 == 3'd4), 8'(5 + md), 1'b0);
            7'h23: if (f3 == 3'd2 || f3 == 3'd0)
                       return mk_rec(1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 4'(md + 1), 1'b1,
                                     (f3 == 3'd2) ? 2'b10 : 2'b00, 1'b0, 8'(4 + md), 1'b0);
            7'h67: if (f3 == 3'd0)
                       return mk_rec(rdnz, 2'b10, 1'b1, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 8'd4, 1'b0);
            default: ;
        endcase
        return mk_rec(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 8'd3, 1'b1);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [19:0] u;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        imm = 12'($urandom);
        u   = 20'($urandom);
        case ($urandom_range(0, 7))
            0:       return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
            1:       return {imm, rs1, 3'b000, rd, 7'b0010011};
            2:       return {u, rd, 7'b0110111};
            3:       return {imm, rs1, 3'b010, rd, 7'b0000011};
            4:       return {imm, rs1, 3'b100, rd, 7'b0000011};
            5:       return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            6:       return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b0100011};
            default: return {imm, rs1, 3'b000, rd, 7'b1100111};
        endcase
    endfunction

    // One cycle; grants for idle memory ports get random junk when noise is on.
    task automatic step();
        @(posedge clk);
        #1;
        if (!imem_req) imem_gnt = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (!dmem_req) dmem_gnt = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic do_instr(input logic [31:0] ins, input int fd, input int md);
        logic [W-1:0] e;
        int n;
        e = model(ins, md);
        exp_q.push_back(e);
        n = 0;
        while (!imem_req && n < 60) begin step(); n++; end
        if (!imem_req) begin check("fetch_req_wait", {31'b0, imem_req}, 32'd1); return; end
        instr    = ins;
        imem_gnt = 1'b0;
        repeat (fd) step();
        imem_gnt = 1'b1;
        step();
        if (e[11:8] != 4'd0) begin
            n = 0;
            while (!dmem_req && n < 60) begin step(); n++; end
            if (!dmem_req) begin check("dmem_req_wait", {31'b0, dmem_req}, 32'd1); return; end
            dmem_gnt = 1'b0;
            repeat (md) step();
            dmem_gnt = 1'b1;
            step();
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", {29'b0, state_dbg}, 32'd0);
        check("rst_strobes", {27'b0, imem_req, dmem_req, ir_we, reg_we, pc_we}, 32'd0);
        check("rst_flags", {30'b0, illegal_instr, timeout_err}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin step(); n++; end
        check("queue_drain", exp_q.size(), 32'd0);
    endtask

    // Monitor
    int           cyc = 0;
    int           start_cyc;
    logic         active = 1'b0, chk_next = 1'b0;
    logic         o_rw, o_src, o_az, o_dwe, o_lu;
    logic [1:0]   o_im, o_dsz;
    int           o_dc;
    logic [W-1:0] obs, exp_rec;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            active   = 1'b0;
            chk_next = 1'b0;
        end else begin
            if (chk_next) begin
                check("next_fetch_req", {31'b0, imem_req}, 32'd1);
                chk_next = 1'b0;
            end
            if (state_dbg == 3'd5)
                check("trap_quiet", {27'b0, imem_req, dmem_req, ir_we, reg_we, pc_we}, 32'd0);
            if (active) begin
                if (state_dbg == 3'd2) begin o_im = imm_sel; o_src = alu_src_imm; o_az = alu_a_zero; end
                if (dmem_req) begin o_dc++; o_dwe = dmem_we; o_dsz = dmem_size; o_lu = load_unsigned; end
                if (reg_we) o_rw = 1'b1;
                if (pc_we || state_dbg == 3'd5) begin
                    obs = mk_rec(o_rw, pc_we ? wb_sel : 2'b00, pc_we ? pc_sel : 1'b0, o_im, o_src, o_az,
                                 4'(o_dc), o_dwe, o_dsz, o_lu, 8'(cyc - start_cyc + 1), illegal_instr);
                    if (exp_q.size() == 0) begin
                        check("unexpected_retire", obs, 32'd0);
                    end else begin
                        exp_rec = exp_q.pop_front();
                        check("retire", obs, exp_rec);
                    end
                    active   = 1'b0;
                    chk_next = pc_we;
                end
            end
            if (ir_we) begin
                active = 1'b1; start_cyc = cyc;
                o_rw = 1'b0; o_src = 1'b0; o_az = 1'b0; o_dwe = 1'b0; o_lu = 1'b0;
                o_im = 2'b00; o_dsz = 2'b00; o_dc = 0;
            end
        end
    end

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] illegal_tab[4];
        illegal_tab[0] = 32'h0000_0000;
        illegal_tab[1] = 32'h4000_0033;
        illegal_tab[2] = 32'h0000_1003;
        illegal_tab[3] = 32'h0000_1067;

        rst_n = 1'b0; instr = 32'h0; imem_gnt = 1'b0; dmem_gnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {29'b0, state_dbg}, 32'd0);
        check("reset_strobes", {27'b0, imem_req, dmem_req, ir_we, reg_we, pc_we}, 32'd0);
        check("reset_flags", {30'b0, illegal_instr, timeout_err}, 32'd0);
        check("pc_init", pc_init, 32'h0000_0000);
        rst_n = 1'b1;
        #1 check("req_before_edge", {31'b0, imem_req}, 32'd0);

        do_instr(32'h0050_0093, 0, 0);  // ADDI x1,x0,5
        do_instr(32'h0030_C103, 0, 3);  // LBU x2,3(x1)
        do_instr(32'h0020_00A3, 0, 0);  // SB x2,1(x0)
        do_instr(32'h0002_80E7, 0, 0);  // JALR x1,0(x5)
        do_instr(32'h0002_8067, 1, 0);  // JALR x0,0(x5)
        do_instr(32'h1234_50B7, 2, 0);  // LUI
        do_instr(32'h0000_A183, 0, 2);  // LW
        do_instr(32'h0000_8033, 0, 0);  // ADD x0,x1,x0

        noise = 1'b1;
        for (int i = 0; i < 40; i++)
            do_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 4));
        drain();

        for (int i = 0; i < 4; i++) begin
            do_instr(illegal_tab[i], $urandom_range(0, 2), 0);
            repeat (4) step();
            check("trap_state", {29'b0, state_dbg}, 32'd5);
            check("trap_flag", {31'b0, illegal_instr}, 32'd1);
            check("trap_drained", exp_q.size(), 32'd0);
            pulse_reset();
        end

        // Reset while a load waits in MEM: request must vanish at once.
        noise = 1'b0;
        while (!imem_req) step();
        instr = 32'h0000_A183;
        imem_gnt = 1'b1;
        step();
        for (int n = 0; n < 10 && !dmem_req; n++) step();
        check("abort_in_mem", {31'b0, dmem_req}, 32'd1);
        step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_dmem_req", {29'b0, dmem_req, pc_we, reg_we}, 32'd0);
        check("abort_state", {29'b0, state_dbg}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_instr(32'h0050_0093, 0, 0);
        drain();

        // STALL_LIMIT=4 instance with fetch grant tied low.
        @(posedge clk);
        #1;
        check("to_reset", {27'b0, to_imem_req, to_timeout_err, to_state_dbg}, 32'd0);
        to_rst_n = 1'b1;
        #1 check("to_req_before_edge", {31'b0, to_imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("to_waiting", {27'b0, to_imem_req, to_timeout_err, to_state_dbg}, {27'b0, 1'b1, 1'b0, 3'd0});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("to_trapped", {27'b0, to_imem_req, to_timeout_err, to_state_dbg}, {27'b0, 1'b0, 1'b1, 3'd5});
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle control FSM for the miniRV core. Sequences fetch, decode, execute, memory and writeback for the miniRV subset: ADD, ADDI, LUI, LW, LBU, SW, SB, JALR. Drives the immediate-select, ALU, register-file, PC and memory-strobe controls of the shared datapath. Handles request/grant handshakes to instruction and data memory, and traps on illegal encodings.

Parameters:
RESET_PC, 32'h0000_0000, value driven on pc_init while the core is in reset
STALL_LIMIT, 255, number of cycles a memory request may wait for grant before timeout_err asserts (0 disables the check)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction register contents from the datapath
imem_gnt  in  1  instruction fetch accepted; instruction data valid this cycle
dmem_gnt  in  1  data access accepted; load data valid this cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data request is a store
dmem_size  out  2  00 byte, 10 word
load_unsigned  out  1  zero-extend byte load (LBU)
ir_we  out  1  capture instruction into IR
imm_sel  out  2  00 I-type, 01 S-type, 10 U-type
alu_src_imm  out  1  ALU operand B is the immediate
alu_a_zero  out  1  ALU operand A forced to 0 (LUI)
reg_we  out  1  register-file write enable
wb_sel  out  2  00 ALU, 01 load data, 10 PC+4
pc_we  out  1  PC update strobe
pc_sel  out  1  0 PC+4, 1 ALU result with bit 0 cleared (JALR)
pc_init  out  32  reset PC value (equals RESET_PC)
illegal_instr  out  1  sticky trap flag
timeout_err  out  1  sticky memory-timeout flag
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset (rst_n low, async): state=FETCH; all strobes (imem_req, dmem_req, ir_we, reg_we, pc_we) and both error flags are 0; selects default to 0. imem_req rises on the first clk edge after rst_n deasserts.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: imem_req=1 until imem_gnt. On the grant cycle ir_we=1, then go to DECODE. If imem_gnt is low, stay in FETCH with imem_req held.
- DECODE: classify opcode, funct3 and funct7 into a registered op code.
  - Legal encodings: ADD 0110011/000/0000000; ADDI 0010011/000; LUI 0110111; LW 0000011/010; LBU 0000011/100; SW 0100011/010; SB 0100011/000; JALR 1100111/000.
  - Anything else: set illegal_instr and go to TRAP.
- EXEC: imm_sel and ALU controls are valid this cycle and held through MEM/WB.
  - ADD: alu_src_imm=0.
  - ADDI, LW, LBU, JALR: imm_sel=I, alu_src_imm=1.
  - SW, SB: imm_sel=S, alu_src_imm=1.
  - LUI: imm_sel=U, alu_src_imm=1, alu_a_zero=1.
  - Next state: loads and stores go to MEM; all others go to WB.
- MEM: dmem_req=1 held until dmem_gnt. dmem_we=1 for stores. dmem_size=10 for LW/SW, 00 for LBU/SB. load_unsigned=1 for LBU.
  - On grant, a load goes to WB.
  - On grant, a store asserts pc_we=1 (pc_sel=0) and goes to FETCH.
- WB: one cycle, then FETCH.
  - reg_we=1. wb_sel is 01 for loads, 10 for JALR, 00 otherwise. pc_we=1.
  - pc_sel=1 for JALR, else 0.
  - reg_we is suppressed when rd (instr[11:7]) is 0.
- Zero-wait latency: ALU/LUI/JALR 4 cycles; loads 5; stores 4.
- TRAP: terminal; all strobes 0. Exited only by reset.
- Timeout: a wait counter (8 bits at default) increments each cycle a request is held without grant and clears on grant. When it reaches STALL_LIMIT, set timeout_err and go to TRAP. The request deasserts the next cycle.
- Boundaries:
  - A grant on the very first request cycle is legal.
  - imem_gnt and dmem_gnt outside their respective states are ignored.
  - Async reset mid-MEM drops dmem_req immediately, with no PC or register side effect.

Decomposition:
- Package minirv_pkg:
  - state_t enum.
  - op_t enum (OP_ADD, OP_ADDI, OP_LUI, OP_LW, OP_LBU, OP_SW, OP_SB, OP_JALR, OP_ILLEGAL).
  - Opcode/funct localparams.
  - imm_sel and wb_sel encodings, shared with the immediate generator mux.
- Sub-module: instr_decoder, purely combinational, instr → op_t. Enables unit-testing decode separately.

Test Plan:
- ADDI x1,x0,5 (0x00500093) with immediate grants: ir_we in cycle 1; imm_sel=00 and alu_src_imm=1 in EXEC; reg_we=1, wb_sel=00 and pc_we=1 in cycle 4; next imem_req in cycle 5.
- LBU x2,3(x1) (0x0030C103) with dmem_gnt delayed 3 cycles: dmem_req held for 4 cycles, dmem_size=00, load_unsigned=1; then WB with wb_sel=01.
- SB x2,1(x0) (0x002000A3): imm_sel=01, dmem_we=1, pc_we on the grant cycle, reg_we never asserted.
- JALR x1,0(x5) (0x000280E7): WB asserts wb_sel=10, pc_sel=1, reg_we=1. The same instruction with rd=0 (0x00028067) keeps reg_we=0.
- Illegal 0x0000_0000: illegal_instr=1 and state=TRAP after DECODE; no strobes thereafter; rst_n pulse returns to FETCH with flags cleared.
- STALL_LIMIT=4 with imem_gnt tied low: timeout_err=1 and state=TRAP after 4 wait cycles; imem_req=0 the following cycle.
